// File: rtl/branch_resolver_if.sv
// Bundle of signals between the ID stage and the branch resolver.
// The ID stage uses the master modport. The resolver uses the slave modport.
interface branch_resolver_if;
  logic        br_valid;
  logic [1:0]  br_op;
  logic [31:0] pc_plus4;
  logic [15:0] imm;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        rs_pending;
  logic        rt_pending;
  logic        kill;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        flush;
  logic [15:0] br_count;
  logic [15:0] taken_count;

  modport master (
    output br_valid, br_op, pc_plus4, imm, rs_data, rt_data,
           rs_pending, rt_pending, kill,
    input  stall, redirect, redirect_pc, flush, br_count, taken_count
  );

  modport slave (
    input  br_valid, br_op, pc_plus4, imm, rs_data, rt_data,
           rs_pending, rt_pending, kill,
    output stall, redirect, redirect_pc, flush, br_count, taken_count
  );
endinterface

// File: rtl/branch_resolver.sv
// ID-stage branch decision unit for a 5-stage MIPS32 pipeline.
// The unit holds the front end while a branch operand is still in flight.
// It then resolves the branch condition and issues a one-cycle redirect/flush
// pulse with the branch target. It also counts resolved and taken branches.
module branch_resolver (
  input  logic               clk,
  input  logic               reset,
  branch_resolver_if.slave   bus
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  state_e      state_r;
  state_e      state_next_s;

  logic        need_rt_s;
  logic        pend_s;
  logic        resolve_s;
  logic        stall_s;
  logic        taken_s;
  logic [31:0] target_s;

  logic        redirect_r;
  logic        flush_r;
  logic [31:0] redirect_pc_r;
  logic [15:0] br_count_r;
  logic [15:0] taken_count_r;

  // Branch condition: BEQ/BNE compare rs with rt. BLEZ/BGTZ test the sign and zero of rs.
  function automatic logic branch_taken(input logic [1:0]  op,
                                        input logic [31:0] rs,
                                        input logic [31:0] rt);
    logic t;
    t = 1'b0;
    case (op)
      2'b00:   t = (rs == rt);
      2'b01:   t = (rs != rt);
      2'b10:   t = rs[31] | (rs == 32'h0000_0000);
      2'b11:   t = !rs[31] & (rs != 32'h0000_0000);
      default: t = 1'b0;
    endcase
    return t;
  endfunction

  // Target address: the word offset is sign-extended, scaled by 4, and added modulo 2^32.
  function automatic logic [31:0] branch_target(input logic [31:0] pc4,
                                                input logic [15:0] off);
    return pc4 + {{14{off[15]}}, off, 2'b00};
  endfunction

  // The rt operand matters only for the two-register compares.
  assign need_rt_s = (bus.br_op == 2'b00) | (bus.br_op == 2'b01);
  assign pend_s    = bus.rs_pending | (need_rt_s & bus.rt_pending);
  assign taken_s   = branch_taken(bus.br_op, bus.rs_data, bus.rt_data);
  assign target_s  = branch_target(bus.pc_plus4, bus.imm);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic. kill always returns to IDLE, because the branch is squashed.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.br_valid && pend_s && !bus.kill) begin
          state_next_s = WAIT;
        end else begin
          state_next_s = IDLE;
        end
      end
      WAIT: begin
        if (bus.kill || !pend_s) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = WAIT;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Per-state outputs: whether this edge resolves the branch, and whether the front end must hold.
  always_comb begin
    resolve_s = 1'b0;
    stall_s   = 1'b0;
    case (state_r)
      IDLE: begin
        resolve_s = bus.br_valid & !pend_s & !bus.kill;
        stall_s   = bus.br_valid &  pend_s & !bus.kill;
      end
      WAIT: begin
        resolve_s = !pend_s & !bus.kill;
        stall_s   =  pend_s & !bus.kill;
      end
      default: begin
        resolve_s = 1'b0;
        stall_s   = 1'b0;
      end
    endcase
  end

  // Redirect pulse, target and statistics. Operands are captured only on the resolve edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      redirect_r    <= 1'b0;
      flush_r       <= 1'b0;
      redirect_pc_r <= 32'h0000_0000;
      br_count_r    <= 16'h0000;
      taken_count_r <= 16'h0000;
    end else if (resolve_s) begin
      redirect_r    <= taken_s;
      flush_r       <= taken_s;
      redirect_pc_r <= target_s;
      br_count_r    <= br_count_r + 16'd1;
      taken_count_r <= taken_count_r + {15'd0, taken_s};
    end else begin
      redirect_r    <= 1'b0;
      flush_r       <= 1'b0;
    end
  end

  // stall stays combinational so the PC and IF/ID freeze in the same cycle. Reset forces it low.
  assign bus.stall       = stall_s & !reset;
  assign bus.redirect    = redirect_r;
  assign bus.flush       = flush_r;
  assign bus.redirect_pc = redirect_pc_r;
  assign bus.br_count    = br_count_r;
  assign bus.taken_count = taken_count_r;

endmodule

// File: tb/tb_branch_resolver.sv
// Scoreboard bench for branch_resolver. Stimulus queues the hand-computed result of each resolve,
// together with the cycle in which that result must appear. A monitor compares the queue
// against the DUT outputs on every falling edge.
module tb_branch_resolver;

  logic clk;
  logic reset;
  int   cyc;
  int   tests;
  int   fails;
  logic mon_en;

  branch_resolver_if bus ();

  branch_resolver dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int          at;
    logic        redir;
    logic [31:0] pc;
    logic [15:0] bc;
    logic [15:0] tc;
  } exp_t;

  exp_t        q[$];
  logic [15:0] m_bc;
  logic [15:0] m_tc;
  logic [15:0] c_bc;
  logic [15:0] c_tc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [31:0] pc4,
                       input logic [15:0] im, input logic [31:0] rs, input logic [31:0] rt,
                       input logic rsp, input logic rtp, input logic k);
    bus.br_valid   = v;
    bus.br_op      = op;
    bus.pc_plus4   = pc4;
    bus.imm        = im;
    bus.rs_data    = rs;
    bus.rt_data    = rt;
    bus.rs_pending = rsp;
    bus.rt_pending = rtp;
    bus.kill       = k;
  endtask

  task automatic idle();
    drive(1'b0, 2'b00, 32'h0, 16'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_stall(input string name, input logic exp);
    #1;
    check(name, {31'd0, bus.stall}, {31'd0, exp});
  endtask

  // A branch resolves on the coming edge. Its result must be visible in the next cycle.
  task automatic push_res(input logic taken, input logic [31:0] target);
    exp_t e;
    m_bc = m_bc + 16'd1;
    m_tc = m_tc + {15'd0, taken};
    e.at = cyc + 1; e.redir = taken; e.pc = target; e.bc = m_bc; e.tc = m_tc;
    q.push_back(e);
  endtask

  task automatic push_rst();
    exp_t e;
    m_bc = 16'h0; m_tc = 16'h0;
    e.at = cyc + 1; e.redir = 1'b0; e.pc = 32'h0; e.bc = 16'h0; e.tc = 16'h0;
    q.push_back(e);
  endtask

  // Monitor: compare a scheduled result, or check that the outputs stay quiet and the counts hold.
  always @(negedge clk) begin
    if (mon_en) begin
      while (q.size() > 0 && q[0].at < cyc) begin
        tests++;
        fails++;
        $display("FAIL missed_result: expected at cycle %0d, now %0d", q[0].at, cyc);
        void'(q.pop_front());
      end
      if (q.size() > 0 && q[0].at == cyc) begin
        exp_t e;
        e = q.pop_front();
        check("mon_redirect", {31'd0, bus.redirect}, {31'd0, e.redir});
        check("mon_flush", {31'd0, bus.flush}, {31'd0, e.redir});
        check("mon_redirect_pc", bus.redirect_pc, e.pc);
        check("mon_br_count", {16'd0, bus.br_count}, {16'd0, e.bc});
        check("mon_taken_count", {16'd0, bus.taken_count}, {16'd0, e.tc});
        c_bc = e.bc;
        c_tc = e.tc;
      end else begin
        check("mon_quiet_redirect", {31'd0, bus.redirect | bus.flush}, 32'd0);
        check("mon_hold_br_count", {16'd0, bus.br_count}, {16'd0, c_bc});
        check("mon_hold_taken_count", {16'd0, bus.taken_count}, {16'd0, c_tc});
      end
    end
  end

  initial begin
    cyc = 0; tests = 0; fails = 0; mon_en = 1'b0;
    m_bc = 16'h0; m_tc = 16'h0; c_bc = 16'h0; c_tc = 16'h0;
    reset = 1'b1;
    idle();
    repeat (2) next_cycle();
    check("reset_redirect", {31'd0, bus.redirect}, 32'd0);
    check("reset_flush", {31'd0, bus.flush}, 32'd0);
    check("reset_redirect_pc", bus.redirect_pc, 32'h0);
    check("reset_br_count", {16'd0, bus.br_count}, 32'd0);
    check("reset_taken_count", {16'd0, bus.taken_count}, 32'd0);
    reset = 1'b0;
    next_cycle();
    mon_en = 1'b1;

    // BEQ taken, no hazard
    next_cycle();
    drive(1'b1, 2'b00, 32'h0040_0004, 16'h0003, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
    push_res(1'b1, 32'h0040_0010);
    check_stall("beq_stall", 1'b0);
    next_cycle();
    idle();
    check("beq_redirect_pc", bus.redirect_pc, 32'h0040_0010);
    check("beq_br_count", {16'd0, bus.br_count}, 32'd1);
    check("beq_taken_count", {16'd0, bus.taken_count}, 32'd1);

    // BNE taken to address 0, then a back-to-back BNE that is not taken
    next_cycle();
    drive(1'b1, 2'b01, 32'h0000_0004, 16'hFFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF0, 1'b0, 1'b0, 1'b0);
    push_res(1'b1, 32'h0000_0000);
    next_cycle();
    drive(1'b1, 2'b01, 32'h0000_0004, 16'hFFFF, 32'h0000_0055, 32'h0000_0055, 1'b0, 1'b0, 1'b0);
    push_res(1'b0, 32'h0000_0000);
    next_cycle();
    idle();
    check("bne_nt_redirect", {31'd0, bus.redirect}, 32'd0);
    check("bne_br_count", {16'd0, bus.br_count}, 32'd3);
    check("bne_taken_count", {16'd0, bus.taken_count}, 32'd2);

    // BEQ with rs pending for 2 cycles. The rs value changes during the stall.
    next_cycle();
    drive(1'b1, 2'b00, 32'h0000_0100, 16'h0010, 32'h0000_DEAD, 32'h0000_1234, 1'b1, 1'b0, 1'b0);
    check_stall("haz_stall_c0", 1'b1);
    next_cycle();
    drive(1'b1, 2'b00, 32'h0000_0100, 16'h0010, 32'h0000_BEEF, 32'h0000_1234, 1'b1, 1'b0, 1'b0);
    check_stall("haz_stall_c1", 1'b1);
    next_cycle();
    drive(1'b1, 2'b00, 32'h0000_0100, 16'h0010, 32'h0000_1234, 32'h0000_1234, 1'b0, 1'b0, 1'b0);
    check_stall("haz_stall_c2", 1'b0);
    check("haz_no_early_redirect", {31'd0, bus.redirect}, 32'd0);
    push_res(1'b1, 32'h0000_0140);
    next_cycle();
    idle();
    check("haz_redirect", {31'd0, bus.redirect}, 32'd1);

    // BLEZ / BGTZ with rt_pending set. rt_pending must be ignored.
    next_cycle();
    drive(1'b1, 2'b10, 32'h0000_1000, 16'h8000, 32'h8000_0000, 32'h0, 1'b0, 1'b1, 1'b0);
    check_stall("blez_stall", 1'b0);
    push_res(1'b1, 32'hFFFE_1000);
    next_cycle();
    drive(1'b1, 2'b11, 32'h0000_2000, 16'h0001, 32'h0000_0000, 32'h5, 1'b0, 1'b1, 1'b0);
    check_stall("bgtz0_stall", 1'b0);
    push_res(1'b0, 32'h0000_2004);
    next_cycle();
    drive(1'b1, 2'b11, 32'h0000_2000, 16'h7FFF, 32'h0000_0001, 32'h5, 1'b0, 1'b1, 1'b0);
    check_stall("bgtz1_stall", 1'b0);
    push_res(1'b1, 32'h0002_1FFC);
    next_cycle();
    idle();
    check("sign_br_count", {16'd0, bus.br_count}, 32'd7);
    check("sign_taken_count", {16'd0, bus.taken_count}, 32'd5);

    // kill in WAIT, in the same cycle that the operand becomes ready. kill wins.
    next_cycle();
    drive(1'b1, 2'b01, 32'h0000_3000, 16'h0004, 32'h1, 32'h2, 1'b1, 1'b0, 1'b0);
    check_stall("kill_wait_stall_before", 1'b1);
    next_cycle();
    drive(1'b1, 2'b01, 32'h0000_3000, 16'h0004, 32'h1, 32'h2, 1'b0, 1'b0, 1'b1);
    check_stall("kill_wait_stall", 1'b0);
    next_cycle();
    idle();
    check("kill_wait_redirect", {31'd0, bus.redirect}, 32'd0);
    check("kill_wait_br_count", {16'd0, bus.br_count}, 32'd7);

    // kill coincident with a branch that has no hazard
    next_cycle();
    drive(1'b1, 2'b00, 32'h0000_4000, 16'h0001, 32'h7, 32'h7, 1'b0, 1'b0, 1'b1);
    check_stall("kill_nohaz_stall", 1'b0);
    next_cycle();
    idle();
    check("kill_nohaz_redirect", {31'd0, bus.redirect}, 32'd0);
    check("kill_nohaz_taken_count", {16'd0, bus.taken_count}, 32'd5);

    // Synchronous reset while in WAIT
    next_cycle();
    drive(1'b1, 2'b00, 32'h0000_5000, 16'h0002, 32'h1, 32'h1, 1'b0, 1'b1, 1'b0);
    check_stall("rst_wait_stall", 1'b1);
    next_cycle();
    reset = 1'b1;
    check_stall("rst_stall_low", 1'b0);
    push_rst();
    next_cycle();
    reset = 1'b0;
    drive(1'b0, 2'b00, 32'h0, 16'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    check_stall("rst_back_to_idle", 1'b0);
    check("rst_redirect_pc", bus.redirect_pc, 32'h0);
    check("rst_br_count", {16'd0, bus.br_count}, 32'd0);
    next_cycle();
    idle();

    // 65536 back-to-back taken branches: both counters wrap to zero
    for (int i = 0; i < 65536; i++) begin
      next_cycle();
      drive(1'b1, 2'b00, 32'h0040_0004, 16'h0003, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
      push_res(1'b1, 32'h0040_0010);
    end
    next_cycle();
    idle();
    check("wrap_taken_count", {16'd0, bus.taken_count}, 32'd0);
    check("wrap_br_count", {16'd0, bus.br_count}, 32'd0);
    check("wrap_last_redirect", {31'd0, bus.redirect}, 32'd1);

    repeat (3) next_cycle();
    check("scoreboard_drained", q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
